// File: rtl/us_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | us_sched_pkg : shared types and default timing for the scan scheduler     |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package us_sched_pkg;

  localparam int DEF_DIST_W       = 10;
  localparam int DEF_GUARD_CYCLES = 6_000_000;
  localparam int DEF_WDOG_CYCLES  = 4_000_000;
  localparam int CNT_W            = 23;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GUARD = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ultrasonic_scan_scheduler_rr_next_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_next_idx : combinational round-robin finder over a sensor mask         |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module rr_next_idx #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             inclusive,
  output logic [IDX_W-1:0] next_idx,
  output logic             found
);

  int w_cand;

  // Scan farthest offset first so the nearest hit is the one that sticks.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    w_cand   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = (int'(cur) + k + (inclusive ? 0 : 1)) % N;
      if (mask[w_cand[IDX_W-1:0]]) begin
        next_idx = w_cand[IDX_W-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ultrasonic_scan_scheduler : round-robin time-sharing of one ranging       |
// |   engine across several HC-SR04-style sensors, with nearest tracking      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module ultrasonic_scan_scheduler
  import us_sched_pkg::*;
#(
  parameter int  NUM_SENSORS  = 4,
  parameter int  DIST_W       = DEF_DIST_W,
  parameter int  GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int  WDOG_CYCLES  = DEF_WDOG_CYCLES,
  localparam int IDX_W        = $clog2(NUM_SENSORS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SENSORS-1:0]        sensor_mask,
  output logic                          meas_start,
  input  logic                          meas_done,
  input  logic                          meas_timeout,
  input  logic [DIST_W-1:0]             meas_distance,
  input  logic                          eng_trig,
  output logic                          eng_echo,
  output logic [NUM_SENSORS-1:0]        sensor_trig,
  input  logic [NUM_SENSORS-1:0]        sensor_echo,
  output logic [IDX_W-1:0]              sel_idx,
  output logic [NUM_SENSORS*DIST_W-1:0] dist_flat,
  output logic [NUM_SENSORS-1:0]        dist_valid,
  output logic [NUM_SENSORS-1:0]        fault,
  output logic [DIST_W-1:0]             near_dist,
  output logic [IDX_W-1:0]              near_idx,
  output logic                          scan_done
);

  localparam logic [CNT_W-1:0] C_GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WDOG_LOAD  = CNT_W'(WDOG_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_first;
  logic [DIST_W-1:0]        r_dist [NUM_SENSORS];
  logic [IDX_W-1:0]         w_next_idx;
  logic                     w_found;
  logic                     w_timeout;
  logic                     w_complete;
  logic [NUM_SENSORS-1:0]   w_upto;
  logic                     w_above;

  rr_next_idx #(
    .N     (NUM_SENSORS),
    .IDX_W (IDX_W)
  ) u_rr (
    .mask      (sensor_mask),
    .cur       (sel_idx),
    .inclusive (r_first),
    .next_idx  (w_next_idx),
    .found     (w_found)
  );

  // Shared counter reaching zero in WAIT means the watchdog expired.
  assign w_timeout  = meas_timeout || (r_cnt == '0);
  assign w_complete = (r_state == WAIT) && (meas_done || w_timeout);
  assign w_upto     = (NUM_SENSORS'(2) << sel_idx) - NUM_SENSORS'(1);
  assign w_above    = |(sensor_mask & ~w_upto);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (enable && |sensor_mask) w_next_state = PICK;
      PICK:    w_next_state = (!enable || !(|sensor_mask)) ? IDLE : START;
      START:   w_next_state = WAIT;
      WAIT:    if (w_complete) w_next_state = enable ? GUARD : IDLE;
      GUARD: begin
        if (!enable)             w_next_state = IDLE;
        else if (r_cnt == '0)    w_next_state = PICK;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    meas_start  = (r_state == START);
    sensor_trig = '0;
    eng_echo    = 1'b0;
    if (r_state == START || r_state == WAIT) sensor_trig[sel_idx] = eng_trig;
    if (r_state == WAIT)                     eng_echo = sensor_echo[sel_idx];
  end

  // Nearest-obstacle reduction: strict compare keeps the lowest index on ties.
  logic [DIST_W-1:0] w_min    [NUM_SENSORS+1];
  logic [IDX_W-1:0]  w_midx   [NUM_SENSORS+1];
  logic              w_mfound [NUM_SENSORS+1];

  assign w_min[0]    = '1;
  assign w_midx[0]   = '0;
  assign w_mfound[0] = 1'b0;

  generate
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_near
      logic w_take;
      assign w_take        = dist_valid[i] && (!w_mfound[i] || (r_dist[i] < w_min[i]));
      assign w_min[i+1]    = w_take ? r_dist[i] : w_min[i];
      assign w_midx[i+1]   = w_take ? IDX_W'(i) : w_midx[i];
      assign w_mfound[i+1] = w_mfound[i] | dist_valid[i];
    end
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_flat
      assign dist_flat[i*DIST_W +: DIST_W] = r_dist[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_idx    <= '0;
      r_first    <= 1'b1;
      r_cnt      <= '0;
      dist_valid <= '0;
      fault      <= '0;
      near_dist  <= '1;
      near_idx   <= '0;
      scan_done  <= 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) r_dist[i] <= '0;
    end else begin
      scan_done  <= 1'b0;
      dist_valid <= dist_valid & sensor_mask;
      near_dist  <= w_min[NUM_SENSORS];
      near_idx   <= w_midx[NUM_SENSORS];

      if (r_state == PICK && w_found) begin
        sel_idx <= w_next_idx;
        r_first <= 1'b0;
      end

      if (r_state == START)  r_cnt <= C_WDOG_LOAD;
      else if (w_complete)   r_cnt <= C_GUARD_LOAD;
      else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;

      if (w_complete) begin
        // A sensor dropped from the mask mid-flight has its result discarded.
        if (sensor_mask[sel_idx]) begin
          if (meas_done && !w_timeout) begin
            r_dist[sel_idx]     <= meas_distance;
            dist_valid[sel_idx] <= 1'b1;
            fault[sel_idx]      <= 1'b0;
          end else begin
            dist_valid[sel_idx] <= 1'b0;
            fault[sel_idx]      <= 1'b1;
          end
        end
        scan_done <= (w_next_state == GUARD) && !w_above;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ultrasonic_scan_scheduler : scoreboard bench with behavioural engine   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ultrasonic_scan_scheduler;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int IW = 2;
  localparam int K_DONE = 0, K_TMO = 1, K_BOTH = 2, K_SILENT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    sensor_mask = '0;
  logic            meas_done = 1'b0;
  logic            meas_timeout = 1'b0;
  logic [DW-1:0]   meas_distance = '0;
  logic            eng_trig = 1'b0;
  logic [N-1:0]    sensor_echo = '0;
  logic            meas_start, eng_echo, scan_done;
  logic [N-1:0]    sensor_trig, dist_valid, fault;
  logic [IW-1:0]   sel_idx, near_idx;
  logic [N*DW-1:0] dist_flat;
  logic [DW-1:0]   near_dist;

  ultrasonic_scan_scheduler #(
    .NUM_SENSORS (N), .DIST_W (DW), .GUARD_CYCLES (50), .WDOG_CYCLES (200)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .sensor_mask (sensor_mask),
    .meas_start (meas_start), .meas_done (meas_done), .meas_timeout (meas_timeout),
    .meas_distance (meas_distance), .eng_trig (eng_trig), .eng_echo (eng_echo),
    .sensor_trig (sensor_trig), .sensor_echo (sensor_echo), .sel_idx (sel_idx),
    .dist_flat (dist_flat), .dist_valid (dist_valid), .fault (fault),
    .near_dist (near_dist), .near_idx (near_idx), .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_bad = 0;
  int            q_sel[$];
  logic [IW-1:0] cur_sel = '0;
  bit            tb_wait = 1'b0;
  int            scan_seen = 0, exp_scan = 0;
  int            m_dist[N];
  bit            m_valid[N];
  bit            m_fault[N];
  int            m_last = 0;
  bit            m_first = 1'b1;
  logic [N-1:0]  mon_et;
  logic          mon_ee;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int model_next();
    if (m_first) begin
      for (int c = 0; c < N; c++) if (sensor_mask[c]) return c;
    end else begin
      for (int k = 1; k <= N; k++) if (sensor_mask[(m_last + k) % N]) return (m_last + k) % N;
    end
    return 0;
  endfunction

  function automatic int model_hi();
    for (int c = N - 1; c >= 0; c--) if (sensor_mask[c]) return c;
    return -1;
  endfunction

  task automatic check_state(input string tag);
    logic [N-1:0]    ev, ef;
    logic [N*DW-1:0] edist;
    int nd, ni;
    bit f;
    nd = 1023; ni = 0; f = 1'b0;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_valid[i];
      ef[i] = m_fault[i];
      edist[i*DW +: DW] = DW'(m_dist[i]);
      if (m_valid[i] && (!f || m_dist[i] < nd)) begin nd = m_dist[i]; ni = i; f = 1'b1; end
    end
    chk({tag, ".dist_valid"}, dist_valid, ev);
    chk({tag, ".fault"},      fault,      ef);
    chk({tag, ".dist_flat"},  dist_flat,  edist);
    chk({tag, ".near_dist"},  near_dist,  nd);
    chk({tag, ".near_idx"},   near_idx,   ni);
  endtask

  // Scoreboard monitor: selection order and result state on each start, routing every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (meas_start) begin
        if (q_sel.size() == 0) begin
          chk("unexpected_meas_start", 1, 0);
        end else begin
          cur_sel = IW'(q_sel.pop_front());
          chk("sel_idx", sel_idx, cur_sel);
          check_state("at_start");
        end
      end
      mon_et = '0;
      mon_ee = 1'b0;
      if (meas_start || tb_wait) mon_et[cur_sel] = eng_trig;
      if (tb_wait && !meas_start) mon_ee = sensor_echo[cur_sel];
      chk("sensor_trig", sensor_trig, mon_et);
      chk("eng_echo", eng_echo, mon_ee);
      if (scan_done) scan_seen++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      eng_trig    = 1'($urandom);
      sensor_echo = N'($urandom);
    end
  end

  task automatic do_meas(input int kind, input int delay, input int d, input bit drop);
    int s, t, dl;
    s = model_next();
    q_sel.push_back(s);
    m_last = s; m_first = 1'b0;
    t = 0;
    while (!meas_start && t < 1000) begin step(); t++; end
    if (!meas_start) begin
      chk("meas_start_wait", 0, 1);
      return;
    end
    tb_wait = 1'b1;
    dl = (kind == K_SILENT) ? 200 : delay;
    for (int k = 0; k < dl; k++) begin
      step();
      if (drop && k == 0) enable = 1'b0;
    end
    meas_distance = DW'(d);
    meas_done     = (kind == K_DONE || kind == K_BOTH);
    meas_timeout  = (kind == K_TMO  || kind == K_BOTH);
    step();
    meas_done = 1'b0; meas_timeout = 1'b0; tb_wait = 1'b0;
    if (kind == K_DONE) begin
      m_dist[s] = d; m_valid[s] = 1'b1; m_fault[s] = 1'b0;
    end else begin
      m_valid[s] = 1'b0; m_fault[s] = 1'b1;
    end
    if (enable && s == model_hi()) exp_scan++;
  endtask

  task automatic change_mask(input logic [N-1:0] nm);
    enable = 1'b0;
    step(2);
    sensor_mask = nm;
    for (int i = 0; i < N; i++) if (!nm[i]) m_valid[i] = 1'b0;
    step(2);
    enable = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_dist[i] = 0; m_valid[i] = 0; m_fault[i] = 0; end
    step(3);
    check_state("reset");
    chk("reset.sel_idx", sel_idx, 0);
    chk("reset.meas_start", meas_start, 0);
    chk("reset.scan_done", scan_done, 0);
    chk("reset.sensor_trig", sensor_trig, 0);
    reset = 1'b1;
    step(2);

    sensor_mask = 4'b1011;
    enable = 1'b1;
    do_meas(K_DONE, 5, 10, 0);
    do_meas(K_DONE, 7, 20, 0);
    do_meas(K_DONE, 3, 30, 0);
    step(3);
    chk("A.dist_valid", dist_valid, 4'b1011);
    chk("A.scan_done_count", scan_seen, 1);
    do_meas(K_DONE, 4, 10, 0);

    change_mask(4'b1111);
    do_meas(K_DONE, 6, 15, 0);
    do_meas(K_TMO, 9, 0, 0);
    do_meas(K_DONE, 2, 60, 0);
    do_meas(K_DONE, 11, 40, 0);
    step(3);
    chk("B.fault", fault, 4'b0100);
    chk("B.dist_valid", dist_valid, 4'b1011);
    chk("B.near_dist", near_dist, 15);
    chk("B.near_idx", near_idx, 1);

    do_meas(K_SILENT, 0, 0, 0);
    step(3);
    chk("C.fault", fault, 4'b0110);
    do_meas(K_DONE, 3, 50, 0);
    do_meas(K_BOTH, 5, 99, 0);
    step(3);
    chk("D.fault", fault, 4'b1010);
    chk("D.dist_valid", dist_valid, 4'b0101);

    do_meas(K_DONE, 8, 77, 1);
    step(300);
    chk("E.dist0", dist_flat[DW-1:0], 77);
    chk("E.pending", q_sel.size(), 0);
    check_state("E");

    for (int it = 0; it < 20; it++) begin
      if (!enable || $urandom_range(0, 3) == 0) change_mask(N'($urandom_range(1, 15)));
      begin
        int r, kd;
        r  = $urandom_range(0, 9);
        kd = (r < 6) ? K_DONE : (r < 8) ? K_TMO : (r < 9) ? K_BOTH : K_SILENT;
        do_meas(kd, $urandom_range(1, 40), $urandom_range(0, 1022), 0);
      end
    end
    step(3);
    check_state("rand_end");

    begin
      int s, t;
      s = model_next();
      q_sel.push_back(s);
      t = 0;
      while (!meas_start && t < 1000) begin step(); t++; end
      chk("G.meas_start_seen", meas_start, 1);
      tb_wait = 1'b1;
      step(3);
      reset = 1'b0;
      step();
      tb_wait = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < N; i++) begin m_dist[i] = 0; m_valid[i] = 0; m_fault[i] = 0; end
      m_first = 1'b1; m_last = 0;
      check_state("G");
      chk("G.sensor_trig", sensor_trig, 0);
      chk("G.meas_start", meas_start, 0);
      chk("G.near_dist", near_dist, 1023);
      chk("G.sel_idx", sel_idx, 0);
      reset = 1'b1;
      step(3);
    end

    chk("end.pending", q_sel.size(), 0);
    chk("end.scan_done_count", scan_seen, exp_scan);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
